// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (transmitter now, receiver later).
//  - 2-bit FSM state encoding, exposed both as localparams and as an enum
//  - clks_per_bit(): number of system clocks per line bit
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] UART_ST_IDLE  = 2'd0;
    localparam logic [1:0] UART_ST_START = 2'd1;
    localparam logic [1:0] UART_ST_DATA  = 2'd2;
    localparam logic [1:0] UART_ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = UART_ST_IDLE,
        ST_START = UART_ST_START,
        ST_DATA  = UART_ST_DATA,
        ST_STOP  = UART_ST_STOP
    } uart_state_e;

    // Integer division; the caller guarantees the result is at least 2.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO. Read data is taken from the storage array at the
// registered read pointer, so the head entry is visible whenever empty=0.
// A write into a full FIFO is accepted only when a read happens in the same
// cycle (the freed slot is the one being written).
// Ports:
//  clk, rst_n        clock, asynchronous active-low reset (flushes pointers)
//  wr_en, wr_data    write request and data
//  rd_en             pop the head entry (ignored when empty)
//  rd_data           head entry
//  full, empty       occupancy flags
//  count             entries currently stored
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(1'b0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]   CNT_ZERO  = (AW + 1)'(1'b0);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             full_s;
    logic             empty_s;
    logic             rd_ok_s;
    logic             wr_ok_s;

    // Occupancy flags and accepted read/write strobes
    always_comb begin
        full_s  = (count_r == CNT_FULL);
        empty_s = (count_r == CNT_ZERO);
        rd_ok_s = rd_en & ~empty_s;
        wr_ok_s = wr_en & (~full_s | rd_ok_s);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_s;
    assign empty   = empty_s;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffers incoming bytes in a small FIFO and serialises each one as an 8N1
// UART frame, LSB first. Queued bytes go out back-to-back: at the end of a
// stop bit the next byte is popped and its start bit begins immediately.
// Ports:
//  clk, rst_n   system clock, asynchronous active-low reset
//  in_valid     byte strobe (no backpressure; dropped when the FIFO is full)
//  in_data      byte to send
//  in_ready     FIFO not full (informational)
//  tx           UART line, registered, idles high
//  tx_busy      frame in progress or bytes still queued
//  overflow     sticky flag: a byte was dropped on a full FIFO
//  fifo_count   entries currently buffered
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            in_ready,
    output logic                            tx,
    output logic                            tx_busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BCW   = $clog2(CPB);
    localparam int BITW  = $clog2(DATA_W);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BCW-1:0]  BAUD_ZERO = BCW'(1'b0);
    localparam logic [BCW-1:0]  BAUD_ONE  = BCW'(1'b1);
    localparam logic [BCW-1:0]  BAUD_LAST = BCW'(CPB - 1);
    localparam logic [BITW-1:0] BIT_ZERO  = BITW'(1'b0);
    localparam logic [BITW-1:0] BIT_ONE   = BITW'(1'b1);
    localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_W - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(1'b0);

    uart_state_e        state_r, state_s;
    logic [BCW-1:0]     baud_r, baud_s;
    logic [BITW-1:0]    bit_r, bit_s;
    logic [DATA_W-1:0]  shift_r, shift_s;
    logic               tx_r, tx_s;
    logic               overflow_r;
    logic               pop_s;
    logic               bit_end_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [DATA_W-1:0]  fifo_rd_data_s;
    logic [CW-1:0]      fifo_count_s;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign bit_end_s = (baud_r == BAUD_LAST);

    // Next-state, baud counter, shift register and line level
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        tx_s    = tx_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                baud_s = BAUD_ZERO;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_rd_data_s;
                    bit_s   = BIT_ZERO;
                    tx_s    = 1'b0;
                    state_s = ST_START;
                end else begin
                    tx_s = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_s  = BAUD_ZERO;
                    tx_s    = shift_r[0];
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_s = BAUD_ZERO;
                    if (bit_r == BIT_LAST) begin
                        tx_s    = 1'b1;
                        state_s = ST_STOP;
                    end else begin
                        // shift_r[1] is the bit that lands in position 0
                        shift_s = {1'b0, shift_r[DATA_W-1:1]};
                        tx_s    = shift_r[1];
                        bit_s   = bit_r + BIT_ONE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_s = BAUD_ZERO;
                    if (!fifo_empty_s) begin
                        // Chain straight into the next start bit
                        pop_s   = 1'b1;
                        shift_s = fifo_rd_data_s;
                        bit_s   = BIT_ZERO;
                        tx_s    = 1'b0;
                        state_s = ST_START;
                    end else begin
                        tx_s    = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + BAUD_ONE;
                end
            end
            default: begin
                baud_s  = BAUD_ZERO;
                tx_s    = 1'b1;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM, counters, shift register and registered tx line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            baud_r  <= BAUD_ZERO;
            bit_r   <= BIT_ZERO;
            shift_r <= {DATA_W{1'b0}};
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
        end
    end

    // Sticky overflow: a push into a full FIFO with no pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (in_valid && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign in_ready   = ~fifo_full_s;
    assign tx         = tx_r;
    assign tx_busy    = (state_r != ST_IDLE) | (fifo_count_s != CNT_ZERO);
    assign overflow   = overflow_r;
    assign fifo_count = fifo_count_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Bench for uart_tx_fifo with CLKS_PER_BIT = 16. A free-running line monitor
// captures every frame on tx (160 samples on the falling clock edge) and
// compares it with the frame queued in the scoreboard when the byte was
// driven. Single-byte frames come from a vector table; bursts, overflow,
// reset mid-frame and push-during-stop are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int FRAME_CYC = 160;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx;
    logic       tx_busy;
    logic       overflow;
    logic [2:0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] sb[$];          // expected frames {stop, data, start}
    int         gap_q[$];       // idle cycles before each captured frame
    int         frames_seen = 0;

    bit           mon_active = 1'b0;
    logic [7:0]   mon_cyc;
    logic [159:0] mon_samp;
    bit           mon_busy_err;
    int           idle_run = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic finish_frame();
        int         bad;
        logic [9:0] got;
        bad = 0;
        for (int b = 0; b < 10; b++) begin
            got[b] = mon_samp[b*16+8];
            for (int c = 0; c < 16; c++) begin
                if (mon_samp[b*16+c] !== mon_samp[b*16]) bad++;
            end
        end
        check("frame_stable", 32'(bad), 32'd0);
        check("frame_busy", 32'(mon_busy_err), 32'd0);
        frames_seen++;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexpected: got frame %0h, expected no frame", got);
        end else begin
            check("frame_data", 32'(got), 32'(sb.pop_front()));
        end
    endtask

    // Line monitor: detects start bits and captures whole frames
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
                idle_run   = 0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active   = 1'b1;
                    mon_samp     = '0;
                    mon_samp[0]  = tx;
                    mon_cyc      = 8'd1;
                    mon_busy_err = (tx_busy !== 1'b1);
                    gap_q.push_back(idle_run);
                    idle_run     = 0;
                end else begin
                    idle_run++;
                end
            end else begin
                mon_samp[mon_cyc] = tx;
                if (tx_busy !== 1'b1) mon_busy_err = 1'b1;
                if (mon_cyc == 8'(FRAME_CYC - 1)) begin
                    mon_active = 1'b0;
                    finish_frame();
                end else begin
                    mon_cyc = mon_cyc + 8'd1;
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frames_arrived", 32'(frames_seen >= target), 32'd1);
    endtask

    task automatic wait_mon_cyc(input int cyc, input int budget);
        int n;
        n = 0;
        while (!(mon_active && int'(mon_cyc) >= cyc) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("mon_reached", 32'(n < budget), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_frame;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        int gbase;
        int changes;
        int lows;
        int busys;
        logic [7:0] burst[6];

        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h01, 10'h202};
        vecs[4] = '{8'h80, 10'h300};
        vecs[5] = '{8'h3C, 10'h278};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state, held for 100 cycles
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({tx, tx_busy, overflow, fifo_count, in_ready} !== 7'b1_0_0_000_1) changes++;
        end
        check("idle_hold", 32'(changes), 32'd0);

        // 2: single-byte frames from the vector table
        for (int v = 0; v < 6; v++) begin
            base = frames_seen;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vecs[v].data;
            sb.push_back(vecs[v].exp_frame);
            @(negedge clk);                 // just after E0
            in_valid = 1'b0;
            check("lat_before_e1", 32'(tx), 32'd1);
            @(negedge clk);                 // just after E1
            check("lat_after_e1", 32'(tx), 32'd0);
            wait_frames(base + 1, FRAME_CYC + 20);
            @(negedge clk);
            check("busy_after_frame", 32'(tx_busy), 32'd0);
            check("tx_idle_after", 32'(tx), 32'd1);
            repeat (3) @(negedge clk);
        end

        // 3: three-byte burst, contiguous frames
        base  = frames_seen;
        gbase = gap_q.size();
        burst[0] = 8'h12; burst[1] = 8'h34; burst[2] = 8'h56;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = burst[i];
            sb.push_back({1'b1, burst[i], 1'b0});
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_frames(base + 3, 3 * FRAME_CYC + 20);
        check("burst_frames", 32'(frames_seen - base), 32'd3);
        check("burst_gap1", 32'(gap_q.size() > gbase + 1 ? gap_q[gbase+1] : -1), 32'd0);
        check("burst_gap2", 32'(gap_q.size() > gbase + 2 ? gap_q[gbase+2] : -1), 32'd0);
        check("burst_overflow", 32'(overflow), 32'd0);
        repeat (5) @(negedge clk);

        // 4: six consecutive pushes, the sixth is dropped
        base = frames_seen;
        for (int i = 0; i < 6; i++) burst[i] = 8'h11 + 8'(i);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                check("full_ready", 32'(in_ready), 32'd0);
                check("full_count", 32'(fifo_count), 32'd4);
                check("ovf_before_6th", 32'(overflow), 32'd0);
            end
            in_valid = 1'b1;
            in_data  = burst[i];
            if (i < 5) sb.push_back({1'b1, burst[i], 1'b0});
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("ovf_after_6th", 32'(overflow), 32'd1);
        check("count_after_drop", 32'(fifo_count), 32'd4);
        wait_frames(base + 5, 5 * FRAME_CYC + 20);
        repeat (200) @(negedge clk);
        check("ovf_frames", 32'(frames_seen - base), 32'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_busy_end", 32'(tx_busy), 32'd0);

        // 5: reset during data bit 3 with two bytes queued
        burst[0] = 8'hA1; burst[1] = 8'hB2; burst[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = burst[i];
            sb.push_back({1'b1, burst[i], 1'b0});
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_mon_cyc(72, 300);              // middle of data bit 3
        check("queued_before_rst", 32'(fifo_count), 32'd2);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_busy", 32'(tx_busy), 32'd0);
        check("rst_mid_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h5A;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        base  = frames_seen;
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busys++;
        end
        check("post_rst_tx_low", 32'(lows), 32'd0);
        check("post_rst_busy", 32'(busys), 32'd0);
        check("post_rst_count", 32'(fifo_count), 32'd0);
        check("post_rst_frames", 32'(frames_seen - base), 32'd0);

        // 6: push during the stop bit of the last queued frame
        base  = frames_seen;
        gbase = gap_q.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hD4;
        sb.push_back({1'b1, 8'hD4, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        wait_mon_cyc(150, 300);             // inside the stop bit
        in_valid = 1'b1;
        in_data  = 8'hE7;
        sb.push_back({1'b1, 8'hE7, 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        wait_frames(base + 2, 2 * FRAME_CYC + 20);
        check("stop_push_gap", 32'(gap_q.size() > gbase + 1 ? gap_q[gbase+1] : -1), 32'd0);
        @(negedge clk);
        check("stop_push_busy_end", 32'(tx_busy), 32'd0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
